decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second pipeline stage, directly downstream of fetch.
- Takes the fetched PC and the instruction word returned by instruction memory.
- Decodes MIPS-I subset fields and control, drives register-file read addresses, and registers the result into the ID/EX pipeline register.
- Detects load-use hazards and drives the fetch stall; squashes on taken-branch redirect.

Parameters:
- ADDR_START, 32'h8002_0000, PC value loaded into pc_ex_out on reset.

Ports:
- clk_in  input  1  CPU clock.
- rst_n_in  input  1  synchronous active-low reset.
- pc_in  input  32  PC of insn_in, from fetch pc_decode_out.
- insn_in  input  32  instruction word from instruction memory.
- insn_valid_in  input  1  insn_in/pc_in hold a real instruction.
- flush_in  input  1  taken-branch redirect from execute (same signal as fetch pc_sel).
- ex_mem_read_in  input  1  instruction now in EX is a load.
- ex_rt_in  input  5  destination register of that EX instruction.
- stall_out  output  1  to fetch stall_in; holds fetch and this stage's input.
- rs_addr_out  output  5  register-file read address A, combinational.
- rt_addr_out  output  5  register-file read address B, combinational.
- pc_ex_out  output  32  registered PC to execute.
- valid_ex_out  output  1  registered; 0 = bubble.
- dest_ex_out  output  5  registered write-back register.
- imm_ex_out  output  32  registered extended immediate.
- alu_op_ex_out  output  4  registered ALU operation.
- alu_src_imm_ex_out  output  1  registered; ALU B operand = immediate.
- reg_write_ex_out  output  1  registered write-back enable.
- mem_read_ex_out  output  1  registered load.
- mem_write_ex_out  output  1  registered store.
- access_size_ex_out  output  2  registered memory size: 00 byte, 10 word.
- branch_ex_out  output  2  registered: 00 none, 01 beq, 10 bne, 11 jump/jr.
- illegal_ex_out  output  1  registered; unsupported opcode seen.

Behaviour:
Combinational decode:
- rs_addr_out = insn[25:21]; rt_addr_out = insn[20:16].

ALU op encoding:
- 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sltu, 8 sll, 9 srl, 10 sra, 11 lui, 15 none.

R-type (op 0x00):
- funct 00 sll, 02 srl, 03 sra, 08 jr, 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2a slt, 2b sltu.
- dest = rd.
- jr: branch 11, no write.

I-type:
- addi/addiu 08/09, slti 0a, sltiu 0b: sign-extend immediate.
- andi 0c, ori 0d, xori 0e: zero-extend immediate.
- lui 0f: imm = {insn[15:0], 16'h0}.
- Loads: lw 23 (word), lb 20, lbu 24 (byte).
- Stores: sw 2b (word), sb 28 (byte).
- beq 04, bne 05: imm = sign-extended offset << 2.
- dest = rt.

J-type:
- j 02: branch 11, imm = {4'b0, insn[25:0], 2'b00}.
- jal 03: same as j, plus dest 31, reg_write 1.

Write-back and illegal:
- reg_write forced 0 whenever dest == 0.
- Unknown op/funct: illegal 1, all enables 0, alu_op 15.

Hazard (combinational):
- stall_out = insn_valid_in & ex_mem_read_in & (ex_rt_in != 0) & (ex_rt_in == rs | (uses_rt & ex_rt_in == rt)) & ~flush_in.
- uses_rt is 1 for R-type, beq, bne, sw, sb.

Pipeline register, updated every posedge clk_in, priority order:
1. rst_n_in = 0:
   - valid_ex_out 0; pc_ex_out ADDR_START; all enables, illegal, branch, dest, imm 0; alu_op 15.
2. flush_in = 1: insert bubble (valid and all enables 0, branch 00, illegal 0). Also squashes a pending stall.
3. stall_out = 1: insert bubble. Inputs are not consumed; the same instruction is re-decoded next cycle.
4. insn_valid_in = 0: insert bubble.
5. Otherwise: load decoded fields; valid_ex_out 1.

Timing and boundaries:
- Latency: 1 cycle from insn_in to EX outputs.
- Bubble keeps pc_ex_out at its last value.
- Reset dominates flush and stall.
- Reset mid-stall: stall_out recomputes from inputs; EX register is cleared.
- Stall lasts exactly 1 cycle for a single load-use pair, because the next cycle's EX holds the bubble (ex_mem_read_in 0).

Test Plan:
- Reset: hold rst_n_in 0 for 2 cycles -> valid_ex_out 0, pc_ex_out 8002_0000, alu_op 15; release, feed nop 0000_0000 at pc 8002_0000 -> valid 1, reg_write 0 (dest 0).
- Decode sweep: addiu $2,$0,-1 (2402_FFFF) -> imm FFFF_FFFF, alu 0, src_imm 1, dest 2. ori $3,$3,0x8000 (3463_8000) -> imm 0000_8000. lui $4,0x1234 (3C04_1234) -> imm 1234_0000, alu 11. jal 0x100 (0C00_0040) -> dest 31, branch 11, imm 0000_0100.
- Load-use: EX has lw $5 (ex_mem_read_in 1, ex_rt_in 5); decode add $6,$5,$7 (00A7_3020) -> stall_out 1, next edge valid_ex_out 0. Then ex_mem_read_in 0 -> add issues, alu 0, dest 6.
- No false stall: ex_rt_in 0 with ex_mem_read_in 1 -> stall 0. addi $8,$5,1 with ex_rt_in 8 (rt not a source) -> stall 0.
- Flush priority: stall condition present and flush_in 1 -> stall_out 0, bubble registered. beq $1,$2,-1 (1022_FFFF) next -> imm FFFF_FFFC, branch 01.
- Illegal: insn FC00_0000 -> illegal_ex_out 1, valid 1, reg_write 0, mem enables 0. Reset asserted the same cycle -> illegal_ex_out 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side inputs, hazard inputs and ID/EX outputs of the decode stage
interface decode_stage_if;
    logic [31:0] pc_in;
    logic [31:0] insn_in;
    logic        insn_valid_in;
    logic        flush_in;
    logic        ex_mem_read_in;
    logic [4:0]  ex_rt_in;
    logic        stall_out;
    logic [4:0]  rs_addr_out;
    logic [4:0]  rt_addr_out;
    logic [31:0] pc_ex_out;
    logic        valid_ex_out;
    logic [4:0]  dest_ex_out;
    logic [31:0] imm_ex_out;
    logic [3:0]  alu_op_ex_out;
    logic        alu_src_imm_ex_out;
    logic        reg_write_ex_out;
    logic        mem_read_ex_out;
    logic        mem_write_ex_out;
    logic [1:0]  access_size_ex_out;
    logic [1:0]  branch_ex_out;
    logic        illegal_ex_out;
    modport master (
        output pc_in, insn_in, insn_valid_in, flush_in, ex_mem_read_in, ex_rt_in,
        input  stall_out, rs_addr_out, rt_addr_out, pc_ex_out, valid_ex_out, dest_ex_out,
               imm_ex_out, alu_op_ex_out, alu_src_imm_ex_out, reg_write_ex_out,
               mem_read_ex_out, mem_write_ex_out, access_size_ex_out, branch_ex_out,
               illegal_ex_out
    );
    modport slave (
        input  pc_in, insn_in, insn_valid_in, flush_in, ex_mem_read_in, ex_rt_in,
        output stall_out, rs_addr_out, rt_addr_out, pc_ex_out, valid_ex_out, dest_ex_out,
               imm_ex_out, alu_op_ex_out, alu_src_imm_ex_out, reg_write_ex_out,
               mem_read_ex_out, mem_write_ex_out, access_size_ex_out, branch_ex_out,
               illegal_ex_out
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: MIPS-I subset decode, load-use stall detection and ID/EX pipeline register
module decode_stage #(
    parameter logic [31:0] ADDR_START = 32'h8002_0000
) (
    input logic           clk_in,
    input logic           rst_n_in,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        src;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  sz;
        logic [1:0]  br;
        logic        ill;
    } ex_t;
    localparam ex_t EX_RST = '{valid: 1'b0, pc: ADDR_START, alu: 4'hf, default: '0};
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sx;
    logic        uses_rt, stall;
    ex_t         dec, ex_d, ex_q;
    assign op = bus.insn_in[31:26];
    assign rs = bus.insn_in[25:21];
    assign rt = bus.insn_in[20:16];
    assign rd = bus.insn_in[15:11];
    assign fn = bus.insn_in[5:0];
    assign sx = {{16{bus.insn_in[15]}}, bus.insn_in[15:0]};
    always_comb begin
        dec      = '0;
        dec.alu  = 4'hf;
        dec.dest = rt;
        dec.imm  = sx;
        uses_rt  = 1'b0;
        case (op)
            6'h00: begin
                dec.dest = rd;
                dec.imm  = {27'd0, bus.insn_in[10:6]};
                dec.rw   = 1'b1;
                uses_rt  = 1'b1;
                case (fn)
                    6'h00: dec.alu = 4'd8;
                    6'h02: dec.alu = 4'd9;
                    6'h03: dec.alu = 4'd10;
                    6'h08: begin dec.br = 2'b11; dec.rw = 1'b0; end
                    6'h20, 6'h21: dec.alu = 4'd0;
                    6'h22, 6'h23: dec.alu = 4'd1;
                    6'h24: dec.alu = 4'd2;
                    6'h25: dec.alu = 4'd3;
                    6'h26: dec.alu = 4'd4;
                    6'h27: dec.alu = 4'd5;
                    6'h2a: dec.alu = 4'd6;
                    6'h2b: dec.alu = 4'd7;
                    default: dec.ill = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h0a, 6'h0b: begin
                dec.alu = (op == 6'h0a) ? 4'd6 : (op == 6'h0b) ? 4'd7 : 4'd0;
                dec.src = 1'b1;
                dec.rw  = 1'b1;
            end
            6'h0c, 6'h0d, 6'h0e: begin
                dec.alu = (op == 6'h0c) ? 4'd2 : (op == 6'h0d) ? 4'd3 : 4'd4;
                dec.imm = {16'd0, bus.insn_in[15:0]};
                dec.src = 1'b1;
                dec.rw  = 1'b1;
            end
            6'h0f: begin
                dec.alu = 4'd11;
                dec.imm = {bus.insn_in[15:0], 16'd0};
                dec.src = 1'b1;
                dec.rw  = 1'b1;
            end
            6'h20, 6'h23, 6'h24: begin
                dec.alu = 4'd0;
                dec.src = 1'b1;
                dec.rw  = 1'b1;
                dec.mr  = 1'b1;
                dec.sz  = (op == 6'h23) ? 2'b10 : 2'b00;
            end
            6'h28, 6'h2b: begin
                dec.alu = 4'd0;
                dec.src = 1'b1;
                dec.mw  = 1'b1;
                dec.sz  = (op == 6'h2b) ? 2'b10 : 2'b00;
                uses_rt = 1'b1;
            end
            6'h04, 6'h05: begin
                dec.alu = 4'd1;
                dec.br  = (op == 6'h04) ? 2'b01 : 2'b10;
                dec.imm = {sx[29:0], 2'b00};
                uses_rt = 1'b1;
            end
            6'h02, 6'h03: begin
                dec.br   = 2'b11;
                dec.imm  = {4'd0, bus.insn_in[25:0], 2'b00};
                dec.dest = (op == 6'h03) ? 5'd31 : 5'd0;
                dec.rw   = (op == 6'h03);
            end
            default: dec.ill = 1'b1;
        endcase
        // An unsupported encoding must leave no side effects downstream
        if (dec.ill) begin
            dec     = '0;
            dec.alu = 4'hf;
            dec.ill = 1'b1;
        end
        dec.rw = dec.rw & (dec.dest != 5'd0);
    end
    assign stall = bus.insn_valid_in & bus.ex_mem_read_in & (bus.ex_rt_in != 5'd0) &
                   ((bus.ex_rt_in == rs) | (uses_rt & (bus.ex_rt_in == rt))) & ~bus.flush_in;
    always_comb begin
        ex_d = ex_q;
        if (bus.flush_in | stall | ~bus.insn_valid_in) begin
            ex_d.valid = 1'b0;
            ex_d.rw    = 1'b0;
            ex_d.mr    = 1'b0;
            ex_d.mw    = 1'b0;
            ex_d.br    = 2'b00;
            ex_d.ill   = 1'b0;
        end else begin
            ex_d       = dec;
            ex_d.valid = 1'b1;
            ex_d.pc    = bus.pc_in;
        end
    end
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) ex_q <= EX_RST;
        else ex_q <= ex_d;
    end
    assign bus.stall_out          = stall;
    assign bus.rs_addr_out        = rs;
    assign bus.rt_addr_out        = rt;
    assign bus.pc_ex_out          = ex_q.pc;
    assign bus.valid_ex_out       = ex_q.valid;
    assign bus.dest_ex_out        = ex_q.dest;
    assign bus.imm_ex_out         = ex_q.imm;
    assign bus.alu_op_ex_out      = ex_q.alu;
    assign bus.alu_src_imm_ex_out = ex_q.src;
    assign bus.reg_write_ex_out   = ex_q.rw;
    assign bus.mem_read_ex_out    = ex_q.mr;
    assign bus.mem_write_ex_out   = ex_q.mw;
    assign bus.access_size_ex_out = ex_q.sz;
    assign bus.branch_ex_out      = ex_q.br;
    assign bus.illegal_ex_out     = ex_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage against a behavioural decode model
module tb_decode_stage;
    localparam logic [31:0] AS = 32'h8002_0000;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        src;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  sz;
        logic [1:0]  br;
        logic        ill;
    } ex_t;
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    int   errors = 0;
    int   checks = 0;
    ex_t  act, exp_ex, nxt;
    logic exp_stall;
    decode_stage_if bus();
    decode_stage #(.ADDR_START(AS)) dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus));
    always #5 clk_in = ~clk_in;
    assign act = {bus.valid_ex_out, bus.pc_ex_out, bus.dest_ex_out, bus.imm_ex_out,
                  bus.alu_op_ex_out, bus.alu_src_imm_ex_out, bus.reg_write_ex_out,
                  bus.mem_read_ex_out, bus.mem_write_ex_out, bus.access_size_ex_out,
                  bus.branch_ex_out, bus.illegal_ex_out};
    function automatic ex_t rst_state();
        ex_t e;
        e = '0;
        e.pc = AS;
        e.alu = 4'hf;
        return e;
    endfunction
    // Instruction semantics written from the ISA tables: what EX must see for an issued insn
    function automatic ex_t model(input logic [31:0] p, input logic [31:0] i);
        ex_t e;
        logic [5:0] op, fn;
        logic [31:0] sx;
        op = i[31:26];
        fn = i[5:0];
        sx = {{16{i[15]}}, i[15:0]};
        e = '0;
        e.valid = 1'b1;
        e.pc = p;
        e.alu = 4'hf;
        e.dest = i[20:16];
        e.imm = sx;
        if (op == 6'h00) begin
            e.dest = i[15:11];
            e.imm = 32'(i[10:6]);
            e.rw = 1'b1;
            if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) e.alu = 4'(fn == 0 ? 8 : 7 + fn);
            else if (fn == 6'h08) begin e.br = 2'b11; e.rw = 1'b0; end
            else if (fn == 6'h20 || fn == 6'h21) e.alu = 4'd0;
            else if (fn == 6'h22 || fn == 6'h23) e.alu = 4'd1;
            else if (fn >= 6'h24 && fn <= 6'h27) e.alu = 4'(fn - 6'h24 + 2);
            else if (fn == 6'h2a || fn == 6'h2b) e.alu = 4'(fn - 6'h2a + 6);
            else e.ill = 1'b1;
        end else if (op == 6'h08 || op == 6'h09) begin e.alu = 0; e.src = 1; e.rw = 1; end
        else if (op == 6'h0a || op == 6'h0b) begin e.alu = 4'(op - 6'h0a + 6); e.src = 1; e.rw = 1; end
        else if (op >= 6'h0c && op <= 6'h0e) begin
            e.alu = 4'(op - 6'h0c + 2); e.src = 1; e.rw = 1; e.imm = 32'(i[15:0]);
        end
        else if (op == 6'h0f) begin e.alu = 11; e.src = 1; e.rw = 1; e.imm = i[15:0] * 32'h10000; end
        else if (op == 6'h20 || op == 6'h23 || op == 6'h24) begin
            e.alu = 0; e.src = 1; e.rw = 1; e.mr = 1; e.sz = (op == 6'h23) ? 2 : 0;
        end
        else if (op == 6'h28 || op == 6'h2b) begin
            e.alu = 0; e.src = 1; e.mw = 1; e.sz = (op == 6'h2b) ? 2 : 0;
        end
        else if (op == 6'h04 || op == 6'h05) begin e.alu = 1; e.br = 2'(op - 3); e.imm = sx * 4; end
        else if (op == 6'h02 || op == 6'h03) begin
            e.br = 3; e.imm = i[25:0] * 4; e.dest = (op == 6'h03) ? 31 : 0; e.rw = (op == 6'h03);
        end
        else e.ill = 1'b1;
        if (e.ill) begin
            e = '0; e.valid = 1'b1; e.pc = p; e.alu = 4'hf; e.ill = 1'b1;
        end
        if (e.dest == 0) e.rw = 1'b0;
        return e;
    endfunction
    task automatic apply(input logic r, input logic [31:0] p, input logic [31:0] i, input logic v,
                         input logic emr, input logic [4:0] ert, input logic fl);
        logic urt;
        rst_n_in = r;
        bus.pc_in = p;
        bus.insn_in = i;
        bus.insn_valid_in = v;
        bus.ex_mem_read_in = emr;
        bus.ex_rt_in = ert;
        bus.flush_in = fl;
        urt = i[31:26] inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h2b};
        exp_stall = v && emr && ert != 0 && (ert == i[25:21] || (urt && ert == i[20:16])) && !fl;
        if (!r) nxt = rst_state();
        else if (fl || exp_stall || !v) begin
            nxt = exp_ex;
            nxt.valid = 0; nxt.rw = 0; nxt.mr = 0; nxt.mw = 0; nxt.br = 0; nxt.ill = 0;
        end else nxt = model(p, i);
        #1;
    endtask
    task automatic tick();
        @(posedge clk_in);
        exp_ex = nxt;
        @(negedge clk_in);
    endtask
    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            apply(0, $urandom, $urandom, 1, 0, 0, 0);
            tick();
            checks++;
            if ({act.valid, act.pc, act.alu} !== {1'b0, AS, 4'hf}) begin
                errors++; $display("FAIL reset_fields got=%h want=%h", {act.valid, act.pc, act.alu}, {1'b0, AS, 4'hf});
            end
            checks++;
            if (act !== exp_ex) begin errors++; $display("FAIL reset_state got=%h want=%h", act, exp_ex); end
        end
        apply(1, AS, 32'h0, 1, 0, 0, 0);
        tick();
        checks++;
        if ({act.valid, act.rw, act.pc} !== {2'b10, AS}) begin
            errors++; $display("FAIL reset_nop got=%h want=%h", {act.valid, act.rw, act.pc}, {2'b10, AS});
        end
        checks++;
        if (act !== exp_ex) begin errors++; $display("FAIL reset_nop_all got=%h want=%h", act, exp_ex); end
    endtask
    task automatic test_decode_sweep();
        apply(1, AS + 4, 32'h2402_FFFF, 1, 0, 0, 0);
        tick();
        checks++;
        if ({act.imm, act.alu, act.src, act.dest} !== {32'hFFFF_FFFF, 4'd0, 1'b1, 5'd2}) begin
            errors++; $display("FAIL addiu got=%h want=%h", {act.imm, act.alu, act.src, act.dest}, {32'hFFFF_FFFF, 4'd0, 1'b1, 5'd2});
        end
        apply(1, AS + 8, 32'h3463_8000, 1, 0, 0, 0);
        tick();
        checks++;
        if (act.imm !== 32'h0000_8000) begin errors++; $display("FAIL ori_imm got=%h want=%h", act.imm, 32'h0000_8000); end
        checks++;
        if (act !== exp_ex) begin errors++; $display("FAIL ori_all got=%h want=%h", act, exp_ex); end
        apply(1, AS + 12, 32'h3C04_1234, 1, 0, 0, 0);
        tick();
        checks++;
        if ({act.imm, act.alu} !== {32'h1234_0000, 4'd11}) begin
            errors++; $display("FAIL lui got=%h want=%h", {act.imm, act.alu}, {32'h1234_0000, 4'd11});
        end
        apply(1, AS + 16, 32'h0C00_0040, 1, 0, 0, 0);
        tick();
        checks++;
        if ({act.dest, act.br, act.imm, act.rw} !== {5'd31, 2'b11, 32'h0000_0100, 1'b1}) begin
            errors++; $display("FAIL jal got=%h want=%h", {act.dest, act.br, act.imm, act.rw}, {5'd31, 2'b11, 32'h0000_0100, 1'b1});
        end
        checks++;
        if (act !== exp_ex) begin errors++; $display("FAIL jal_all got=%h want=%h", act, exp_ex); end
    endtask
    task automatic test_load_use();
        apply(1, AS + 20, 32'h00A7_3020, 1, 1, 5, 0);
        checks++;
        if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b want=1", bus.stall_out); end
        tick();
        checks++;
        if ({act.valid, act.pc} !== {1'b0, AS + 32'd16}) begin
            errors++; $display("FAIL lu_bubble got=%h want=%h", {act.valid, act.pc}, {1'b0, AS + 32'd16});
        end
        apply(1, AS + 20, 32'h00A7_3020, 1, 0, 0, 0);
        checks++;
        if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL lu_release got=%b want=0", bus.stall_out); end
        tick();
        checks++;
        if ({act.valid, act.alu, act.dest, act.rw} !== {1'b1, 4'd0, 5'd6, 1'b1}) begin
            errors++; $display("FAIL lu_issue got=%h want=%h", {act.valid, act.alu, act.dest, act.rw}, {1'b1, 4'd0, 5'd6, 1'b1});
        end
    endtask
    task automatic test_no_false_stall();
        apply(1, AS + 24, 32'h00A7_3020, 1, 1, 0, 0);
        checks++;
        if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL nfs_zero got=%b want=0", bus.stall_out); end
        tick();
        apply(1, AS + 28, 32'h20A8_0001, 1, 1, 8, 0);
        checks++;
        if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL nfs_rt got=%b want=0", bus.stall_out); end
        tick();
        checks++;
        if (act !== exp_ex) begin errors++; $display("FAIL nfs_addi got=%h want=%h", act, exp_ex); end
    endtask
    task automatic test_flush();
        apply(1, AS + 32, 32'h00A7_3020, 1, 1, 5, 1);
        checks++;
        if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL fl_stall got=%b want=0", bus.stall_out); end
        tick();
        checks++;
        if ({act.valid, act.rw, act.br, act.pc} !== {1'b0, 1'b0, 2'b00, AS + 32'd28}) begin
            errors++; $display("FAIL fl_bubble got=%h want=%h", {act.valid, act.rw, act.br, act.pc}, {1'b0, 1'b0, 2'b00, AS + 32'd28});
        end
        apply(1, AS + 36, 32'h1022_FFFF, 1, 0, 0, 0);
        tick();
        checks++;
        if ({act.imm, act.br, act.valid} !== {32'hFFFF_FFFC, 2'b01, 1'b1}) begin
            errors++; $display("FAIL beq got=%h want=%h", {act.imm, act.br, act.valid}, {32'hFFFF_FFFC, 2'b01, 1'b1});
        end
    endtask
    task automatic test_illegal();
        apply(1, AS + 40, 32'hFC00_0000, 1, 0, 0, 0);
        tick();
        checks++;
        if ({act.ill, act.valid, act.rw, act.mr, act.mw} !== 5'b11000) begin
            errors++; $display("FAIL illegal got=%b want=11000", {act.ill, act.valid, act.rw, act.mr, act.mw});
        end
        apply(0, AS + 40, 32'hFC00_0000, 1, 0, 0, 0);
        tick();
        checks++;
        if ({act.ill, act.valid} !== 2'b00) begin
            errors++; $display("FAIL illegal_rst got=%b want=00", {act.ill, act.valid});
        end
    endtask
    function automatic logic [31:0] rand_insn();
        logic [5:0] ops [0:18];
        logic [5:0] fns [0:13];
        logic [5:0] op;
        ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b,
                6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h23, 6'h24, 6'h28, 6'h2b};
        fns = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                6'h26, 6'h27, 6'h2a, 6'h2b};
        op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 18)];
        if (op != 6'h00)
            return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        return {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom), ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 13)]};
    endfunction
    task automatic test_random();
        logic [31:0] i;
        for (int k = 0; k < 400; k++) begin
            i = rand_insn();
            apply($urandom_range(0, 29) != 0, $urandom, i, $urandom_range(0, 3) != 0,
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
            checks++;
            if ({bus.stall_out, bus.rs_addr_out, bus.rt_addr_out} !== {exp_stall, i[25:21], i[20:16]}) begin
                errors++; $display("FAIL rnd_comb k=%0d insn=%h got=%h want=%h", k, i,
                    {bus.stall_out, bus.rs_addr_out, bus.rt_addr_out}, {exp_stall, i[25:21], i[20:16]});
            end
            tick();
            checks++;
            if (act !== exp_ex) begin
                errors++; $display("FAIL rnd_ex k=%0d insn=%h got=%h want=%h", k, i, act, exp_ex);
            end
        end
    endtask
    initial begin
        exp_ex = rst_state();
        nxt = exp_ex;
        bus.pc_in = '0;
        bus.insn_in = '0;
        bus.insn_valid_in = 1'b0;
        bus.flush_in = 1'b0;
        bus.ex_mem_read_in = 1'b0;
        bus.ex_rt_in = '0;
        @(negedge clk_in);
        test_reset();
        test_decode_sweep();
        test_load_use();
        test_no_false_stall();
        test_flush();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
